// File: rtl/data_cache.sv
// Direct-mapped, write-through, write-allocate data cache with one 32-bit word
// per line. Loads that hit complete in one cycle from the local arrays. Misses
// and all stores go out to a word-addressed backing memory.
module data_cache #(
    parameter int CACHE_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_request,
    input  logic        write_request,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        response,
    output logic [31:0] read_data,
    output logic        memory_read_request,
    output logic        memory_write_request,
    input  logic        memory_response,
    output logic [31:0] memory_addr,
    input  logic [31:0] memory_read_data,
    output logic [31:0] memory_write_data
);

    localparam int IW = $clog2(CACHE_SIZE);
    localparam int TW = 30 - IW;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_MEM_READ  = 2'd1;
    localparam logic [1:0] S_MEM_WRITE = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    logic [1:0]            r_state;
    logic [CACHE_SIZE-1:0] r_valid;
    logic [TW-1:0]         r_tagMem  [CACHE_SIZE];
    logic [31:0]           r_dataMem [CACHE_SIZE];

    logic        r_response;
    logic [31:0] r_readData;
    logic        r_memRead;
    logic        r_memWrite;
    logic [31:0] r_memAddr;
    logic [31:0] r_memWData;

    logic [IW-1:0] w_reqIndex;
    logic [TW-1:0] w_reqTag;
    logic          w_hit;
    logic [IW-1:0] w_fillIndex;
    logic [TW-1:0] w_fillTag;
    logic          w_fillEn;
    logic [31:0]   w_fillData;
    logic          w_unused;

    // The byte offset plays no part in a word-granular cache.
    assign w_unused = &{1'b0, addr[1:0]};

    // Incoming request is looked up directly; the fill uses the latched memory
    // address so requester address changes during a memory access are ignored.
    assign w_reqIndex  = addr[IW+1:2];
    assign w_reqTag    = addr[31:IW+2];
    assign w_hit       = r_valid[w_reqIndex] && (r_tagMem[w_reqIndex] == w_reqTag);
    assign w_fillIndex = r_memAddr[IW+1:2];
    assign w_fillTag   = r_memAddr[31:IW+2];
    assign w_fillEn    = memory_response &&
                         ((r_state == S_MEM_READ) || (r_state == S_MEM_WRITE));
    assign w_fillData  = (r_state == S_MEM_READ) ? memory_read_data : r_memWData;

    // Valid bits are the only part of the storage that needs clearing on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (w_fillEn) begin
            r_valid[w_fillIndex] <= 1'b1;
        end
    end

    // Tag/data arrays: a read-miss fill or a store allocates the whole line.
    always_ff @(posedge clk) begin
        if (w_fillEn) begin
            r_tagMem[w_fillIndex]  <= w_fillTag;
            r_dataMem[w_fillIndex] <= w_fillData;
        end
    end

    // Control FSM: serve a request from IDLE, wait on memory, then one DONE turnaround.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_response <= 1'b0;
            r_readData <= '0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_memAddr  <= '0;
            r_memWData <= '0;
        end else begin
            r_response <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (write_request) begin
                        r_memWrite <= 1'b1;
                        r_memAddr  <= {addr[31:2], 2'b00};
                        r_memWData <= write_data;
                        r_state    <= S_MEM_WRITE;
                    end else if (read_request) begin
                        if (w_hit) begin
                            r_readData <= r_dataMem[w_reqIndex];
                            r_response <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_memRead <= 1'b1;
                            r_memAddr <= {addr[31:2], 2'b00};
                            r_state   <= S_MEM_READ;
                        end
                    end
                end
                S_MEM_READ: begin
                    if (memory_response) begin
                        r_readData <= memory_read_data;
                        r_response <= 1'b1;
                        r_memRead  <= 1'b0;
                        r_state    <= S_DONE;
                    end
                end
                S_MEM_WRITE: begin
                    if (memory_response) begin
                        r_response <= 1'b1;
                        r_memWrite <= 1'b0;
                        r_state    <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign response             = r_response;
    assign read_data            = r_readData;
    assign memory_read_request  = r_memRead;
    assign memory_write_request = r_memWrite;
    assign memory_addr          = r_memAddr;
    assign memory_write_data    = r_memWData;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache. The backing memory is a small model that
// answers a held request on the third clock with a one-cycle pulse; word i of
// memory starts out as 32'hD000_0000 | i.
module tb_data_cache;

    logic        clk;
    logic        reset;
    logic        read_request;
    logic        write_request;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        response;
    logic [31:0] read_data;
    logic        memory_read_request;
    logic        memory_write_request;
    logic        memory_response;
    logic [31:0] memory_addr;
    logic [31:0] memory_read_data;
    logic [31:0] memory_write_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [2048];
    int          memCnt;
    int          memReads    = 0;
    int          memWrites   = 0;
    int          memRdCycles = 0;
    logic        bothSeen    = 1'b0;

    data_cache #(.CACHE_SIZE(1024)) dut (
        .clk                  (clk),
        .reset                (reset),
        .read_request         (read_request),
        .write_request        (write_request),
        .addr                 (addr),
        .write_data           (write_data),
        .response             (response),
        .read_data            (read_data),
        .memory_read_request  (memory_read_request),
        .memory_write_request (memory_write_request),
        .memory_response      (memory_response),
        .memory_addr          (memory_addr),
        .memory_read_data     (memory_read_data),
        .memory_write_data    (memory_write_data)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Backing memory model: respond to a held request after a short delay.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            memory_response  <= 1'b0;
            memory_read_data <= '0;
            memCnt           <= 0;
            for (int i = 0; i < 2048; i++) mem[i] <= 32'hD000_0000 | i;
        end else begin
            memory_response <= 1'b0;
            if ((memory_read_request || memory_write_request) && !memory_response) begin
                if (memCnt == 2) begin
                    memCnt           <= 0;
                    memory_response  <= 1'b1;
                    memory_read_data <= mem[memory_addr[12:2]];
                    if (memory_write_request) mem[memory_addr[12:2]] <= memory_write_data;
                end else begin
                    memCnt <= memCnt + 1;
                end
            end
        end
    end

    // Transaction counters and exclusivity watch on the memory side.
    always @(posedge clk) begin
        if (memory_read_request && memory_response) memReads++;
        if (memory_write_request && memory_response) memWrites++;
        if (memory_read_request) memRdCycles++;
        if (memory_read_request && memory_write_request) bothSeen = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Hold a load until response, then verify data, memory traffic and latency.
    task automatic applyStimulus(input string tag, input logic [31:0] a,
                                 input logic [31:0] expData, input bit expMiss);
        int          rd0;
        int          cyc;
        logic        got;
        logic [31:0] seenAddr;
        rd0      = memReads;
        cyc      = 0;
        got      = 1'b0;
        seenAddr = '1;
        addr         = a;
        read_request = 1'b1;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (memory_read_request) seenAddr = memory_addr;
            if (response) got = 1'b1;
        end
        read_request = 1'b0;
        checkOutput({tag, "_resp"}, {31'd0, got}, 32'd1);
        checkOutput({tag, "_data"}, read_data, expData);
        checkOutput({tag, "_memrd"}, 32'(memReads - rd0), expMiss ? 32'd1 : 32'd0);
        if (expMiss) checkOutput({tag, "_maddr"}, seenAddr, {a[31:2], 2'b00});
        else         checkOutput({tag, "_lat"}, 32'(cyc), 32'd1);
        @(posedge clk); #1;
        checkOutput({tag, "_pulse"}, {31'd0, response}, 32'd0);
    endtask

    // Hold a store until response; scramble addr/data mid-flight to prove latching.
    task automatic doStore(input string tag, input logic [31:0] a, input logic [31:0] d);
        int          wr0;
        int          rd0;
        int          cyc;
        logic        got;
        logic [31:0] seenAddr;
        logic [31:0] seenData;
        wr0      = memWrites;
        rd0      = memReads;
        cyc      = 0;
        got      = 1'b0;
        seenAddr = '1;
        seenData = '1;
        addr          = a;
        write_data    = d;
        write_request = 1'b1;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (memory_write_request) begin
                seenAddr = memory_addr;
                seenData = memory_write_data;
            end
            if (response) got = 1'b1;
            if (cyc == 1) begin
                addr       = 32'hFFFF_FFF0;
                write_data = ~d;
            end
        end
        write_request = 1'b0;
        read_request  = 1'b0;
        checkOutput({tag, "_resp"}, {31'd0, got}, 32'd1);
        checkOutput({tag, "_memwr"}, 32'(memWrites - wr0), 32'd1);
        checkOutput({tag, "_memrd"}, 32'(memReads - rd0), 32'd0);
        checkOutput({tag, "_maddr"}, seenAddr, {a[31:2], 2'b00});
        checkOutput({tag, "_mdata"}, seenData, d);
        @(posedge clk); #1;
        checkOutput({tag, "_pulse"}, {31'd0, response}, 32'd0);
        checkOutput({tag, "_memimg"}, mem[a[12:2]], d);
    endtask

    // Linear directed sequence.
    initial begin
        int rdCyc0;
        reset         = 1'b1;
        read_request  = 1'b0;
        write_request = 1'b0;
        addr          = '0;
        write_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_response", {31'd0, response}, 32'd0);
        checkOutput("reset_memrd", {31'd0, memory_read_request}, 32'd0);
        checkOutput("reset_memwr", {31'd0, memory_write_request}, 32'd0);
        checkOutput("reset_rdata", read_data, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] cold misses and a repeat hit");
        applyStimulus("cold0", 32'h0000_0000, 32'hD000_0000, 1'b1);
        applyStimulus("cold4", 32'h0000_0004, 32'hD000_0001, 1'b1);
        applyStimulus("cold8", 32'h0000_0008, 32'hD000_0002, 1'b1);
        applyStimulus("hit4",  32'h0000_0004, 32'hD000_0001, 1'b0);

        $display("[TB] reset in the middle of a read miss");
        addr         = 32'h0000_000C;
        read_request = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_pre_memrd", {31'd0, memory_read_request}, 32'd1);
        reset        = 1'b1;
        read_request = 1'b0;
        #1;
        checkOutput("rst_response", {31'd0, response}, 32'd0);
        checkOutput("rst_memrd", {31'd0, memory_read_request}, 32'd0);
        checkOutput("rst_memwr", {31'd0, memory_write_request}, 32'd0);
        checkOutput("rst_rdata", read_data, 32'd0);
        checkOutput("rst_maddr", memory_addr, 32'd0);
        checkOutput("rst_mwdata", memory_write_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        applyStimulus("post_rst0", 32'h0000_0000, 32'hD000_0000, 1'b1);

        $display("[TB] store then load");
        doStore("st14", 32'h0000_0014, 32'h6A6A_6A6A);
        applyStimulus("ld14", 32'h0000_0014, 32'h6A6A_6A6A, 1'b0);

        $display("[TB] overwrite a cached word");
        applyStimulus("fill4", 32'h0000_0004, 32'hD000_0001, 1'b1);
        doStore("st4", 32'h0000_0004, 32'h736F_6669);
        applyStimulus("ld4", 32'h0000_0006, 32'h736F_6669, 1'b0);

        $display("[TB] index conflict");
        applyStimulus("conf0", 32'h0000_0000, 32'hD000_0000, 1'b0);
        applyStimulus("conf1000", 32'h0000_1000, 32'hD000_0400, 1'b1);
        applyStimulus("conf0again", 32'h0000_0000, 32'hD000_0000, 1'b1);

        $display("[TB] simultaneous read and write");
        rdCyc0       = memRdCycles;
        read_request = 1'b1;
        doStore("both20", 32'h0000_0020, 32'h1234_5678);
        checkOutput("both20_rdcyc", 32'(memRdCycles - rdCyc0), 32'd0);
        applyStimulus("ld20", 32'h0000_0020, 32'h1234_5678, 1'b0);

        checkOutput("exclusive_req", {31'd0, bothSeen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
